// File: rtl/rx_os_assembler.sv
`default_nettype none
// ============================================================================
// Module   : rx_os_assembler
// Purpose  : Per-lane receive ordered-set assembler for Gen1/Gen2 (8b/10b).
//            Hunts for COM at word position 0, assembles 16-symbol TS1/TS2
//            sets into a 128-bit word with a one-cycle strobe, discards
//            SKP/EIEOS, flags EIOS and reports framing aborts.
// Revision : 1.0 - initial release
// ============================================================================
module rx_os_assembler #(
  parameter int PIPEWIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PIPEWIDTH-1:0]   rxData,
  input  logic [PIPEWIDTH/8-1:0] rxDataK,
  input  logic                   rxValid,
  input  logic                   rxElectricalIdle,
  output logic [127:0]           orderedSet,
  output logic                   validOrderedSet,
  output logic [1:0]             osType,
  output logic                   eiosDetected,
  output logic                   symbolError
);

  localparam int         N      = PIPEWIDTH / 8;
  localparam logic [7:0] COM    = 8'hBC;
  localparam logic [7:0] SKP    = 8'h1C;
  localparam logic [7:0] EIE    = 8'hFC;
  localparam logic [7:0] IDL    = 8'h7C;
  localparam logic [7:0] PAD    = 8'hF7;
  localparam logic [7:0] TS1_ID = 8'h4A;
  localparam logic [7:0] TS2_ID = 8'h45;

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t       state, state_n;
  logic [4:0]   count, count_n;
  logic [127:0] assembly, assembly_n;
  logic         eios_mode, eios_mode_n;
  logic         complete, eios_hit, abort, go, stop;
  logic [4:0]   base, pos;
  logic [7:0]   sym;
  logic         symk;

  // Walk the word's symbols in arrival order, classifying each by its set position.
  always_comb begin
    state_n     = state;
    count_n     = count;
    assembly_n  = assembly;
    eios_mode_n = eios_mode;
    complete    = 1'b0;
    eios_hit    = 1'b0;
    abort       = 1'b0;
    go          = 1'b0;
    stop        = 1'b0;
    base        = count;
    pos         = '0;
    sym         = '0;
    symk        = 1'b0;
    if (!rxValid || rxElectricalIdle) begin
      // Lost lock or idle: silently drop whatever was partially collected.
      state_n = HUNT;
      count_n = '0;
    end else begin
      if (rxDataK[0] && rxData[7:0] == COM) begin
        // A COM at word position 0 always (re)starts a set; mid-set it aborts the old one.
        go          = 1'b1;
        base        = '0;
        eios_mode_n = 1'b0;
        abort       = (state == COLLECT);
      end else if (state == COLLECT) begin
        go = 1'b1;
      end
      if (go) begin
        state_n = COLLECT;
        count_n = base + 5'(N);
        for (int k = 0; k < N; k++) begin
          if (!stop) begin
            pos  = base + 5'(k);
            sym  = rxData[8*k +: 8];
            symk = rxDataK[k];
            assembly_n[{pos[3:0], 3'b000} +: 8] = sym;
            if (pos == 5'd1 && symk) begin
              case (sym)
                SKP, EIE: begin
                  stop    = 1'b1;
                  state_n = HUNT;
                  count_n = '0;
                end
                IDL:     eios_mode_n = 1'b1;
                PAD:     ;
                default: begin
                  abort   = 1'b1;
                  stop    = 1'b1;
                  state_n = HUNT;
                  count_n = '0;
                end
              endcase
            end else if (eios_mode_n && (pos == 5'd2 || pos == 5'd3)) begin
              if (!(symk && sym == IDL)) begin
                abort   = 1'b1;
                stop    = 1'b1;
                state_n = HUNT;
                count_n = '0;
              end else if (pos == 5'd3) begin
                eios_hit = 1'b1;
                stop     = 1'b1;
                state_n  = HUNT;
                count_n  = '0;
              end
            end else if (pos != 5'd0 && symk && !(pos == 5'd2 && sym == PAD)) begin
              abort   = 1'b1;
              stop    = 1'b1;
              state_n = HUNT;
              count_n = '0;
            end
            if (!stop && pos == 5'd15) begin
              complete = 1'b1;
              stop     = 1'b1;
              state_n  = HUNT;
              count_n  = '0;
            end
          end
        end
      end
    end
  end

  // State, partial-set storage and registered one-cycle outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= HUNT;
      count           <= '0;
      assembly        <= '0;
      eios_mode       <= 1'b0;
      orderedSet      <= '0;
      validOrderedSet <= 1'b0;
      osType          <= 2'd0;
      eiosDetected    <= 1'b0;
      symbolError     <= 1'b0;
    end else begin
      state           <= state_n;
      count           <= count_n;
      assembly        <= assembly_n;
      eios_mode       <= eios_mode_n && (state_n == COLLECT);
      validOrderedSet <= complete;
      eiosDetected    <= eios_hit;
      symbolError     <= abort;
      if (complete) begin
        orderedSet <= assembly_n;
        if (assembly_n[55:48] == TS1_ID)      osType <= 2'd1;
        else if (assembly_n[55:48] == TS2_ID) osType <= 2'd2;
        else                                  osType <= 2'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rx_os_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_os_assembler
// Purpose  : Directed, table-driven checks of rx_os_assembler at 8/16/32-bit
//            PIPE widths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_os_assembler;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0]   d8;  logic [0:0] k8;  logic v8, e8;
  logic [127:0] os8; logic vos8, eios8, err8; logic [1:0] ty8;
  logic [15:0]  d16; logic [1:0] k16; logic v16, e16;
  logic [127:0] os16; logic vos16, eios16, err16; logic [1:0] ty16;
  logic [31:0]  d32; logic [3:0] k32; logic v32, e32;
  logic [127:0] os32; logic vos32, eios32, err32; logic [1:0] ty32;

  rx_os_assembler #(.PIPEWIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .rxData(d8), .rxDataK(k8), .rxValid(v8),
    .rxElectricalIdle(e8), .orderedSet(os8), .validOrderedSet(vos8),
    .osType(ty8), .eiosDetected(eios8), .symbolError(err8));
  rx_os_assembler #(.PIPEWIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .rxData(d16), .rxDataK(k16), .rxValid(v16),
    .rxElectricalIdle(e16), .orderedSet(os16), .validOrderedSet(vos16),
    .osType(ty16), .eiosDetected(eios16), .symbolError(err16));
  rx_os_assembler #(.PIPEWIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .rxData(d32), .rxDataK(k32), .rxValid(v32),
    .rxElectricalIdle(e32), .orderedSet(os32), .validOrderedSet(vos32),
    .osType(ty32), .eiosDetected(eios32), .symbolError(err32));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Current ordered set being built as symbols + K flags.
  logic [7:0] s[16];
  logic       sk[16];

  task automatic make_ts(input logic [7:0] link, input logic [7:0] lane, input logic [7:0] id);
    s[0] = 8'hBC; sk[0] = 1'b1;
    s[1] = link;  sk[1] = (link == 8'hF7);
    s[2] = lane;  sk[2] = (lane == 8'hF7);
    s[3] = 8'h10; s[4] = 8'h02; s[5] = 8'h00;
    for (int i = 3; i < 16; i++) sk[i] = 1'b0;
    for (int i = 6; i < 16; i++) s[i] = id;
  endtask

  function automatic logic [127:0] packed_set();
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  typedef struct {
    logic [7:0]   d;
    logic         k;
    logic         ei;
    logic [2:0]   exp;   // {validOrderedSet, eiosDetected, symbolError}
    logic         chk;
    logic [127:0] os;
    logic [1:0]   ty;
  } row_t;
  row_t tbl[$];

  task automatic add(input logic [7:0] d, input logic k, input logic ei, input logic [2:0] exp,
                     input logic chk, input logic [127:0] os, input logic [1:0] ty);
    row_t r;
    r.d = d; r.k = k; r.ei = ei; r.exp = exp; r.chk = chk; r.os = os; r.ty = ty;
    tbl.push_back(r);
  endtask

  task automatic drive32(input int w);
    d32 = {s[4*w+3], s[4*w+2], s[4*w+1], s[4*w]};
    k32 = {sk[4*w+3], sk[4*w+2], sk[4*w+1], sk[4*w]};
  endtask

  logic [127:0] ts1, ts2p, ts2a;
  int n_vos, n_err, n_eios, first, second, cyc;
  logic [1:0] ty_at_strobe;

  initial begin
    make_ts(8'hF7, 8'hF7, 8'h4A); ts1  = packed_set();
    make_ts(8'hF7, 8'hF7, 8'h45); ts2p = packed_set();
    make_ts(8'h01, 8'h00, 8'h45); ts2a = packed_set();

    reset = 1'b1;
    d8 = '0;  k8 = '0;  v8 = 1'b1;  e8 = 1'b0;
    d16 = '0; k16 = '0; v16 = 1'b1; e16 = 1'b0;
    d32 = '0; k32 = '0; v32 = 1'b1; e32 = 1'b0;
    tick(); tick();
    check("reset w8",  {os8, vos8, ty8, eios8, err8}, '0);
    check("reset w16", {os16, vos16, ty16, eios16, err16}, '0);
    check("reset w32", {os32, vos32, ty32, eios32, err32}, '0);
    #2 reset = 1'b0;

    // ---------------- PIPEWIDTH=8 table ----------------
    make_ts(8'hF7, 8'hF7, 8'h4A);
    for (int i = 0; i < 16; i++)
      add(s[i], sk[i], 1'b0, (i == 15) ? 3'b100 : 3'b000, i == 15, ts1, 2'd1);
    add(8'h00, 1'b0, 1'b0, 3'b000, 1'b0, '0, 2'd0);
    add(8'hBC, 1'b1, 1'b0, 3'b000, 1'b0, '0, 2'd0);
    add(8'h7C, 1'b1, 1'b0, 3'b000, 1'b0, '0, 2'd0);
    add(8'h7C, 1'b1, 1'b0, 3'b000, 1'b0, '0, 2'd0);
    add(8'h7C, 1'b1, 1'b0, 3'b010, 1'b0, '0, 2'd0);
    add(8'h00, 1'b0, 1'b0, 3'b000, 1'b0, '0, 2'd0);
    for (int i = 0; i < 16; i++) begin
      if (i == 9) add(8'h1C, 1'b1, 1'b0, 3'b001, 1'b0, '0, 2'd0);
      else        add(s[i], sk[i], 1'b0, 3'b000, i == 15, ts1, 2'd1);
    end
    for (int i = 0; i < 16; i++)
      add(s[i], sk[i], i == 8, 3'b000, i == 15, ts1, 2'd1);
    for (int i = 0; i < 4; i++)
      add(s[i], sk[i], 1'b0, 3'b000, 1'b0, '0, 2'd0);
    make_ts(8'hF7, 8'hF7, 8'h45);
    for (int i = 0; i < 16; i++)
      add(s[i], sk[i], 1'b0, (i == 0) ? 3'b001 : (i == 15) ? 3'b100 : 3'b000, i == 15, ts2p, 2'd2);

    for (int i = 0; i < tbl.size(); i++) begin
      d8 = tbl[i].d; k8 = tbl[i].k; e8 = tbl[i].ei; v8 = 1'b1;
      tick();
      check($sformatf("w8 row%0d pulses", i), {vos8, eios8, err8}, tbl[i].exp);
      if (tbl[i].chk) begin
        check($sformatf("w8 row%0d orderedSet", i), os8, tbl[i].os);
        check($sformatf("w8 row%0d osType", i), ty8, tbl[i].ty);
      end
    end
    d8 = '0; k8 = '0; e8 = 1'b0;

    // ---------------- PIPEWIDTH=16: SKP set then TS1 ----------------
    n_vos = 0; n_err = 0; n_eios = 0; ty_at_strobe = 2'd0;
    d16 = 16'h1CBC; k16 = 2'b11; tick();
    n_vos += int'(vos16); n_err += int'(err16); n_eios += int'(eios16);
    d16 = 16'h1C1C; k16 = 2'b11; tick();
    n_vos += int'(vos16); n_err += int'(err16); n_eios += int'(eios16);
    make_ts(8'hF7, 8'hF7, 8'h4A);
    for (int w = 0; w < 8; w++) begin
      d16 = {s[2*w+1], s[2*w]}; k16 = {sk[2*w+1], sk[2*w]};
      tick();
      check($sformatf("w16 word%0d strobe", w), vos16, (w == 7));
      n_vos += int'(vos16); n_err += int'(err16); n_eios += int'(eios16);
      if (vos16) ty_at_strobe = ty16;
    end
    d16 = '0; k16 = '0;
    check("w16 strobe count", n_vos, 1);
    check("w16 symbolError count", n_err, 0);
    check("w16 eios count", n_eios, 0);
    check("w16 osType", ty_at_strobe, 2'd1);
    check("w16 orderedSet", os16, ts1);

    // ---------------- PIPEWIDTH=32: TS2 ----------------
    make_ts(8'h01, 8'h00, 8'h45);
    for (int w = 0; w < 4; w++) begin
      drive32(w); tick();
      check($sformatf("w32 ts2 word%0d pulses", w), {vos32, eios32, err32}, (w == 3) ? 3'b100 : 3'b000);
    end
    check("w32 ts2 orderedSet", os32, ts2a);
    check("w32 ts2 osType", ty32, 2'd2);
    check("w32 ts2 link", os32[15:8], 8'h01);

    // Two back-to-back TS1s: strobes four cycles apart.
    make_ts(8'hF7, 8'hF7, 8'h4A);
    cyc = 0; first = -1; second = -1; n_vos = 0;
    for (int rep = 0; rep < 2; rep++) begin
      for (int w = 0; w < 4; w++) begin
        drive32(w); tick(); cyc++;
        if (vos32) begin
          n_vos++;
          if (first < 0) first = cyc; else second = cyc;
        end
      end
    end
    check("w32 b2b strobe count", n_vos, 2);
    check("w32 b2b spacing", second - first, 4);
    check("w32 b2b osType", ty32, 2'd1);
    check("w32 b2b orderedSet", os32, ts1);

    // Third TS1 cut short by an asynchronous reset during the word carrying symbol 10.
    drive32(0); tick();
    drive32(1); tick();
    drive32(2);
    #2 reset = 1'b1;
    #1;
    check("w32 async reset outputs", {os32, vos32, ty32, eios32, err32}, '0);
    tick();
    #2 reset = 1'b0;
    drive32(3); tick();
    check("w32 post-reset no strobe", {vos32, eios32, err32}, 3'b000);
    d32 = '0; k32 = '0; tick();
    check("w32 post-reset outputs", {os32, vos32, ty32, eios32, err32}, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rx_os_assembler.md
Name: rx_os_assembler

Overview:
- Per-lane upstream stage of the receive LTSSM, Gen1/Gen2 (8b/10b) only.
- Hunts for COM in PIPE RX symbols and assembles 16-symbol TS1/TS2 ordered sets into a 128-bit word with a one-cycle valid strobe.
- Sixteen instances feed the LTSSM's concatenated orderedSets bus and its validOrderedSets input.
- Also discards SKP/EIEOS, flags EIOS, and reports framing errors.

Parameters:
- PIPEWIDTH, 8, PIPE RX data width in bits; legal values 8, 16, 32. N = PIPEWIDTH/8 symbols per cycle.

Ports:
- clk  input  1  receive clock
- reset  input  1  asynchronous, active-high reset
- rxData  input  PIPEWIDTH  PIPE RX symbols; symbol k of the word is in bits [8k+7:8k], k=0 is earliest
- rxDataK  input  N  K-flag per symbol
- rxValid  input  1  PIPE symbol lock / data valid
- rxElectricalIdle  input  1  lane electrical idle
- orderedSet  output  128  last complete ordered set; symbol n in bits [8n+7:8n], COM in [7:0]
- validOrderedSet  output  1  one-cycle strobe; orderedSet is new this cycle
- osType  output  2  with strobe: 1 = TS1 (symbol6=0x4A), 2 = TS2 (symbol6=0x45), 0 = other
- eiosDetected  output  1  one-cycle pulse on COM,IDL,IDL,IDL
- symbolError  output  1  one-cycle pulse on framing abort

Behaviour:
- Reset (async): all outputs 0, orderedSet = 0, state HUNT, symbol count 0.
- States: HUNT, COLLECT.
- HUNT:
  - COM (K=1, 0xBC) accepted only in symbol position 0 of a word; COM elsewhere is ignored.
  - On accept: store the word's symbols as symbols 0..N-1, set count = N, go to COLLECT.
- COLLECT: each word stores N symbols at positions count..count+N-1; count is a 5-bit counter, 0..16.
- Symbol 1 classification, checked when symbol 1 arrives:
  - K28.0 (0x1C, K): SKP set; discard, go to HUNT, no pulses.
  - K28.7 (0xFC, K): EIEOS; discard, go to HUNT, no pulses.
  - K28.3 (0x7C, K): after symbols 2,3 are also K28.3, pulse eiosDetected one cycle after the word holding symbol 3, then go to HUNT. A mismatch in symbol 2 or 3 is a framing abort.
- K rules for symbols 1..15:
  - A K symbol is legal only as PAD (0xF7) in symbols 1 or 2, or per the SKP/EIEOS/EIOS rules above.
  - Any other K symbol is a framing abort: symbolError pulses the next cycle, then HUNT.
  - Exception: COM at position 0 of a word aborts the current set, pulses symbolError, and starts a new collection from that word in the same cycle.
- Completion:
  - On the word that delivers symbol 15, orderedSet and osType update on the following edge.
  - validOrderedSet is high for exactly that one cycle. Latency is 1 clock after the last symbol.
  - orderedSet and osType hold until the next strobe.
- Back-to-back: if the word after completion carries COM at position 0, collection restarts in the strobe cycle; no gap symbols are needed.
- rxValid = 0 or rxElectricalIdle = 1 at any cycle: drop the partial set, go to HUNT, no symbolError. Symbols in that cycle are ignored.
- Simultaneous events: a completion and a later-word abort never coincide, since a set completes only on a full word. An electrical-idle abort takes priority over a COM restart.
- Reset mid-collection: immediate return to reset values; the partial set is never strobed.
- Pulse outputs (validOrderedSet, eiosDetected, symbolError) are mutually exclusive per cycle, except that symbolError and a restart can coincide.

Test Plan:
- PIPEWIDTH=8: COM, PAD(K 0xF7), PAD(K 0xF7), 0x10, 0x02, 0x00, 0x4A, then nine 0x4A -> strobe 1 cycle after symbol 15; orderedSet[7:0]=0xBC, [55:48]=0x4A; osType=1.
- PIPEWIDTH=32: TS2 (link 0x01, lane 0x00, symbols 6..15 = 0x45) in 4 words -> strobe 1 cycle after word 4; osType=2; orderedSet[15:8]=0x01.
- PIPEWIDTH=16: SKP set (COM,SKP,SKP,SKP) followed immediately by TS1 -> exactly one strobe, osType=1, no symbolError.
- PIPEWIDTH=8: COM, K28.3 x3 -> eiosDetected pulses once; no strobe. Then a TS1 with symbol 9 = K 0x1C -> symbolError pulse, no strobe.
- PIPEWIDTH=8: TS1 with rxElectricalIdle asserted at symbol 8 -> no strobe, no symbolError; orderedSet keeps its previous value.
- Two consecutive TS1s at PIPEWIDTH=32 -> strobes exactly 4 cycles apart. Async reset at symbol 10 of a third TS1 -> all outputs 0 immediately, no strobe.
